// File: rtl/iso14443a_bit_encoder_if.sv
// ============================================================================
// tx_interface : bit/byte source-to-sink handshake for the ISO14443-A TX path
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface tx_interface #(
  parameter int BY_BYTE = 0
);
  localparam int c_data_w = (BY_BYTE != 0) ? 8 : 1;

  logic [c_data_w-1:0] data;
  logic                data_valid;
  logic                req;

  modport master (output data, output data_valid, input req);
  modport slave  (input data, input data_valid, output req);
endinterface

`default_nettype wire

// File: rtl/iso14443a_bit_encoder.sv
// ============================================================================
// iso14443a_bit_encoder : 106 kbit/s PICC TX Manchester bit encoder
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module iso14443a_bit_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  tx_interface.slave  in_iface,
  output logic        encoded_data,
  output logic        last_tick
);

  localparam logic [6:0] c_cnt_first = 7'd0;
  localparam logic [6:0] c_cnt_half  = 7'd64;
  localparam logic [6:0] c_cnt_last  = 7'd127;

  logic [6:0] r_cnt;
  logic       r_enc;
  logic       r_valid;

  logic       w_cnt_first;
  logic       w_cnt_half;
  logic       w_cnt_last;

  assign w_cnt_first = (r_cnt == c_cnt_first);
  assign w_cnt_half  = (r_cnt == c_cnt_half);
  assign w_cnt_last  = (r_cnt == c_cnt_last);

  // rst_n is folded in so both strobes drop the instant reset asserts
  assign in_iface.req = rst_n & en & w_cnt_first;
  assign last_tick    = rst_n & en & w_cnt_last;
  assign encoded_data = r_enc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 7'd0;
      r_enc   <= 1'b0;
      r_valid <= 1'b0;
    end else if (!en) begin
      r_cnt   <= 7'd0;
      r_enc   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 7'd1;
      if (w_cnt_first) begin
        r_enc   <= in_iface.data_valid & in_iface.data[0];
        r_valid <= in_iface.data_valid;
      end else if (w_cnt_half && r_valid) begin
        r_enc <= ~r_enc;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iso14443a_bit_encoder.sv
// ============================================================================
// tb_iso14443a_bit_encoder : directed and random-frame bench for the encoder
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iso14443a_bit_encoder;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic encoded_data;
  logic last_tick;

  int n_checks = 0;
  int n_fails  = 0;

  int   gap      = 0;
  logic gap_ok   = 1'b0;
  logic seen_req = 1'b0;
  logic prev_lt  = 1'b0;

  tx_interface #(.BY_BYTE(0)) tx_if ();

  iso14443a_bit_encoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .in_iface     (tx_if),
    .encoded_data (encoded_data),
    .last_tick    (last_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, summary not yet printed");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Samples at the falling edge and applies the protocol rules every cycle
  task automatic wait_neg();
    @(negedge clk);
    if (!rst_n) begin
      n_checks++;
      if (tx_if.req !== 1'b0 || last_tick !== 1'b0) begin
        n_fails++;
        $display("FAIL mon_reset: req=%b last_tick=%b, required 0 0", tx_if.req, last_tick);
      end
      gap_ok = 1'b0; seen_req = 1'b0;
    end else if (!en) begin
      n_checks++;
      if (tx_if.req !== 1'b0 || last_tick !== 1'b0 || $isunknown(encoded_data)) begin
        n_fails++;
        $display("FAIL mon_disabled: req=%b last_tick=%b enc=%b, required 0 0 known",
                 tx_if.req, last_tick, encoded_data);
      end
      gap_ok = 1'b0; seen_req = 1'b0;
    end else begin
      if (last_tick === 1'b1) begin
        n_checks++;
        if (prev_lt || !seen_req) begin
          n_fails++;
          $display("FAIL mon_last_tick: prev_last_tick=%b seen_req=%b, required 0 1", prev_lt, seen_req);
        end
      end
      if (tx_if.req === 1'b1) begin
        if (gap_ok) begin
          n_checks++;
          if (gap != 127) begin
            n_fails++;
            $display("FAIL mon_req_period: %0d idle cycles between req, required 127", gap);
          end
        end
        gap = 0; gap_ok = 1'b1; seen_req = 1'b1;
      end else if (gap_ok) begin
        gap++;
        if (gap > 127) begin
          n_checks++;
          n_fails++;
          $display("FAIL mon_req_missing: %0d cycles without req, required at most 127", gap);
          gap_ok = 1'b0;
        end
      end
    end
    prev_lt = last_tick;
  endtask

  // Runs one enabled frame of n bits and checks every output sample
  task automatic run_frame(input logic [15:0] bits, input logic [15:0] vld, input int n,
                           input string name);
    logic q[$];
    logic exp_s;
    int   nxt;
    for (int b = 0; b < n; b++)
      for (int s = 0; s < 128; s++)
        q.push_back(vld[b] ? (bits[b] ^ (s >= 64)) : 1'b0);
    cyc();
    en = 1'b1; tx_if.data = bits[0]; tx_if.data_valid = vld[0];
    wait_neg();
    n_checks++;
    if (tx_if.req !== 1'b1 || last_tick !== 1'b0 || encoded_data !== 1'b0) begin
      n_fails++;
      $display("FAIL %s_first_req: req=%b last_tick=%b enc=%b, required 1 0 0",
               name, tx_if.req, last_tick, encoded_data);
    end
    for (int j = 0; j < 128 * n; j++) begin
      cyc();
      if (j % 128 == 0) begin
        nxt = j / 128 + 1;
        if (nxt < n) begin
          tx_if.data = bits[nxt]; tx_if.data_valid = vld[nxt];
        end else begin
          tx_if.data = 1'b0; tx_if.data_valid = 1'b0;
        end
      end
      if (j == 128 * n - 1) en = 1'b0;
      wait_neg();
      exp_s = q.pop_front();
      n_checks++;
      if (encoded_data !== exp_s) begin
        n_fails++;
        $display("FAIL %s_sample%0d: enc=%b, required %b", name, j, encoded_data, exp_s);
      end
      n_checks++;
      if (tx_if.req !== ((j % 128 == 127) && (j != 128 * n - 1))) begin
        n_fails++;
        $display("FAIL %s_req%0d: req=%b, required %b", name, j, tx_if.req,
                 (j % 128 == 127) && (j != 128 * n - 1));
      end
      n_checks++;
      if (last_tick !== (j % 128 == 126)) begin
        n_fails++;
        $display("FAIL %s_last_tick%0d: last_tick=%b, required %b", name, j, last_tick, j % 128 == 126);
      end
    end
    cyc();
    wait_neg();
    n_checks++;
    if (encoded_data !== 1'b0 || tx_if.req !== 1'b0 || last_tick !== 1'b0) begin
      n_fails++;
      $display("FAIL %s_after: enc=%b req=%b last_tick=%b, required 0 0 0",
               name, encoded_data, tx_if.req, last_tick);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      wait_neg();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; tx_if.data = 1'b1; tx_if.data_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_neg();
      n_checks++;
      if (encoded_data !== 1'b0 || tx_if.req !== 1'b0 || last_tick !== 1'b0) begin
        n_fails++;
        $display("FAIL reset_state%0d: enc=%b req=%b last_tick=%b, required 0 0 0",
                 i, encoded_data, tx_if.req, last_tick);
      end
    end
    cyc(); en = 1'b0; tx_if.data = 1'b0; tx_if.data_valid = 1'b0;
    wait_neg();
    cyc(); rst_n = 1'b1;
    wait_neg();
    n_checks++;
    if (encoded_data !== 1'b0 || tx_if.req !== 1'b0 || last_tick !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_release: enc=%b req=%b last_tick=%b, required 0 0 0",
               encoded_data, tx_if.req, last_tick);
    end
    idle(3);
  endtask

  task automatic test_single_bits();
    run_frame(16'h0000, 16'h0001, 1, "frame0");
    idle(5);
    run_frame(16'h0001, 16'h0001, 1, "frame1");
    idle(5);
  endtask

  task automatic test_back_to_back();
    run_frame(16'h0000, 16'h0003, 2, "frame00");
    idle(5);
    run_frame(16'h0001, 16'h0003, 2, "frame10");
    idle(5);
  endtask

  task automatic test_invalid_bits();
    run_frame(16'h0001, 16'h0000, 1, "invalid1");
    idle(5);
    run_frame(16'h0007, 16'h0005, 3, "mixed_valid");
    idle(5);
  endtask

  task automatic test_en_abort();
    cyc();
    en = 1'b1; tx_if.data = 1'b1; tx_if.data_valid = 1'b1;
    wait_neg();
    idle(30);
    n_checks++;
    if (encoded_data !== 1'b1) begin
      n_fails++;
      $display("FAIL abort_mid_bit: enc=%b, required 1", encoded_data);
    end
    cyc(); en = 1'b0; tx_if.data_valid = 1'b0;
    wait_neg();
    n_checks++;
    if (tx_if.req !== 1'b0 || last_tick !== 1'b0) begin
      n_fails++;
      $display("FAIL abort_strobes: req=%b last_tick=%b, required 0 0", tx_if.req, last_tick);
    end
    cyc();
    wait_neg();
    n_checks++;
    if (encoded_data !== 1'b0) begin
      n_fails++;
      $display("FAIL abort_clear: enc=%b, required 0", encoded_data);
    end
    idle(3);
    run_frame(16'h0000, 16'h0001, 1, "after_abort");
    idle(5);
  endtask

  task automatic test_reset_mid_frame();
    cyc();
    en = 1'b1; tx_if.data = 1'b1; tx_if.data_valid = 1'b1;
    wait_neg();
    idle(40);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (encoded_data !== 1'b0 || tx_if.req !== 1'b0 || last_tick !== 1'b0) begin
      n_fails++;
      $display("FAIL async_reset: enc=%b req=%b last_tick=%b, required 0 0 0",
               encoded_data, tx_if.req, last_tick);
    end
    wait_neg();
    cyc(); en = 1'b0; tx_if.data_valid = 1'b0;
    wait_neg();
    cyc(); rst_n = 1'b1;
    wait_neg();
    idle(3);
    run_frame(16'h0001, 16'h0001, 1, "after_reset");
    idle(5);
  endtask

  task automatic test_random();
    logic [15:0] bits;
    int n;
    for (int f = 0; f < 40; f++) begin
      n    = int'($urandom_range(10, 1));
      bits = 16'($urandom);
      run_frame(bits, 16'hFFFF, n, "random");
      idle(5);
    end
  endtask

  initial begin
    test_reset();
    test_single_bits();
    test_back_to_back();
    test_invalid_bits();
    test_en_abort();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
